alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Parametrised control sequencer for the ALU datapath. It succeeds the purely combinational opcode decoder. Opcodes arrive over a valid/ready handshake and are decoded into a registered one-hot operation-enable vector. Single-cycle operations retire in one cycle; iterative MULT/DIV hold their enable for WIDTH cycles with step strobes. The block sits between the instruction source and the ALU function units, and owns done and illegal-opcode signalling.

## Interface
- WIDTH, 4: datapath operand width; number of iterations for MULT/DIV; must be ≥ 2
- OP_W, 4: opcode width; must be ≥ 4
- NUM_OPS, 12: width of the enable vector; fixed by the package opcode map
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- op_valid  in  1  opcode offered
- opcode  in  OP_W  operation code
- op_ready  out  1  sequencer can accept; a transfer occurs when op_valid && op_ready
- enable  out  NUM_OPS  registered one-hot operation enable; bit index = opcode
- step  out  1  iteration strobe during MULT/DIV, one per cycle
- step_idx  out  $clog2(WIDTH)  current iteration index, 0..WIDTH-1
- done  out  1  one-cycle pulse in the final cycle of an operation
- busy  out  1  high whenever state ≠ IDLE
- illegal  out  1  one-cycle pulse when an illegal opcode retires
- err_sticky  out  1  latched illegal indication
- err_clr  in  1  clears err_sticky

## Operation
- Opcode map:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT, 7 ADD, 8 SUB, 9 MULT, 10 DIV, 11 SHIFT
  - 12..2^OP_W−1 illegal
- States:
  - IDLE: op_ready=1, all outputs 0.
  - SINGLE: enable[op]=1, done=1 for one cycle.
  - ITER: enable[op]=1, step=1, step_idx counts 0..WIDTH-1.
  - ILL: illegal=1, done=1, enable=0 for one cycle.
- Transitions on accept:
  - MULT/DIV → ITER with step_idx=0.
  - Other legal opcodes → SINGLE.
  - Illegal opcodes → ILL.
- Retirement:
  - ITER at step_idx==WIDTH-1 asserts done. It then accepts the next opcode or returns to IDLE.
  - SINGLE and ILL always retire after one cycle.
- Back-to-back: op_ready is also high in every retiring cycle (SINGLE, ILL, last ITER cycle). An accept in that cycle moves directly to the next op's state with no idle bubble.
- opcode is latched on accept; input changes afterwards are ignored.
- enable is always one-hot or all-zero, never multi-hot.
- err_sticky: set on ILL entry, cleared by err_clr. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: state → IDLE next edge; the in-flight op is dropped with no done.

## Timing
- Reset values: op_ready=0 during reset and 1 in the first cycle after rst_n deasserts. All other outputs (enable, step, step_idx, done, busy, illegal, err_sticky) reset to 0.
- Accept at edge N → enable visible in cycle N+1, all outputs registered.
- Single-cycle op: enable and done in cycle N+1. Sustained throughput is 1 op/cycle.
- MULT/DIV: enable in cycles N+1..N+WIDTH; done in cycle N+WIDTH.
- op_valid held without op_ready: the opcode stays pending; the producer must hold it stable.

## Configuration
- ALU_SEQ_ILLEGAL_TRAP_EN defined:
  - Illegal opcodes take the ILL path.
  - illegal and err_sticky are live.
- Not defined:
  - Illegal opcodes are treated as NOP: one cycle with enable=0 and done=1.
  - illegal and err_sticky are tied to 0; err_clr is ignored.
  - Ports remain present in both builds.

## Structure
- Package alu_seq_pkg holds:
  - opcode enum with the map above
  - NUM_OPS=12 and MIN_OP_W=4
  - state enum
  - functions is_multi(op) and is_legal(op)
- Sub-module alu_op_decoder: combinational opcode → {one-hot vector, is_multi, is_legal}. The top level registers its outputs.

## Test plan
- Reset then opcode 7 with op_valid=1 → cycle+1: enable=0x080, done=1; following cycle enable=0.
- WIDTH=4, opcode 9 → enable=0x200 for 4 cycles, step_idx 0,1,2,3, done only with idx 3. op_ready=0 for idx 0..2.
- Opcodes 0,1,2 on consecutive cycles with op_valid held → enable=0x001,0x002,0x004 on consecutive cycles, done each cycle.
- Opcode 13 with macro → illegal=1, done=1, enable=0, err_sticky=1 until err_clr. Without macro → done=1, illegal=0, err_sticky=0.
- DIV accepted, rst_n=0 at step_idx 2 → next cycle all outputs 0, no done. After release, op_ready=1.
- err_clr and illegal retirement in the same cycle → err_sticky remains 1.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// alu_seq_pkg: shared definitions for the ALU operation sequencer.
//   - alu_op_e     : opcode map (bit index of the enable vector = opcode)
//   - seq_state_e  : sequencer FSM states
//   - NUM_OPS      : width of the one-hot enable vector
//   - MIN_OP_W     : smallest opcode width that covers the map
//   - is_multi()   : opcode runs for WIDTH iterations (MULT/DIV)
//   - is_legal()   : opcode is inside the map
package alu_seq_pkg;

    localparam int unsigned NUM_OPS  = 12;
    localparam int unsigned MIN_OP_W = 4;

    typedef enum logic [3:0] {
        OP_AND   = 4'd0,
        OP_NAND  = 4'd1,
        OP_OR    = 4'd2,
        OP_NOR   = 4'd3,
        OP_XOR   = 4'd4,
        OP_XNOR  = 4'd5,
        OP_NOT   = 4'd6,
        OP_ADD   = 4'd7,
        OP_SUB   = 4'd8,
        OP_MULT  = 4'd9,
        OP_DIV   = 4'd10,
        OP_SHIFT = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SINGLE,
        ST_ITER,
        ST_ILL
    } seq_state_e;

    // Opcodes are passed zero-extended to 32 bits so any OP_W up to 32 works.
    function automatic logic is_legal(input logic [31:0] op);
        return op < NUM_OPS;
    endfunction

    function automatic logic is_multi(input logic [31:0] op);
        return (op == 32'(OP_MULT)) || (op == 32'(OP_DIV));
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: opcode valid/ready handshake.
//   op_valid : producer offers an opcode
//   opcode   : operation code, held stable while op_valid && !op_ready
//   op_ready : sequencer can accept; transfer when op_valid && op_ready
// Modports: master (instruction source), slave (sequencer).
interface alu_op_sequencer_if #(
    parameter int unsigned OP_W = 4
) ();
    logic            op_valid;
    logic [OP_W-1:0] opcode;
    logic            op_ready;

    modport master (output op_valid, output opcode, input  op_ready);
    modport slave  (input  op_valid, input  opcode, output op_ready);
endinterface

// File: rtl/alu_op_sequencer_decoder.sv
// alu_op_decoder: purely combinational opcode decode.
//   opcode : operation code (OP_W bits, OP_W <= 32)
//   onehot : one-hot operation vector, all-zero for illegal opcodes
//   multi  : opcode is an iterative op (MULT/DIV)
//   legal  : opcode is inside the opcode map
module alu_op_decoder
    import alu_seq_pkg::*;
#(
    parameter int unsigned OP_W = 4
) (
    input  logic [OP_W-1:0]    opcode,
    output logic [NUM_OPS-1:0] onehot,
    output logic               multi,
    output logic               legal
);

    logic [31:0] op_ext;

    assign op_ext = 32'(opcode);
    assign multi  = is_multi(op_ext);
    assign legal  = is_legal(op_ext);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_OPS; i++) begin
            if (op_ext == i) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts opcodes over a valid/ready handshake and drives
// a registered one-hot enable vector for the ALU function units.
// Single-cycle ops retire in one cycle; MULT/DIV hold their enable for WIDTH
// cycles with a step strobe and iteration index.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   op_if       : slave side of the opcode handshake (op_valid/opcode/op_ready)
//   enable      : one-hot op enable (bit index = opcode), or all-zero
//   step        : iteration strobe during MULT/DIV
//   step_idx    : current iteration 0..WIDTH-1
//   done        : pulse in the final cycle of every operation
//   busy        : sequencer is not idle
//   illegal     : pulse when an illegal opcode retires
//   err_sticky  : latched illegal indication
//   err_clr     : clears err_sticky (set wins over clear)
//
// Build option ALU_SEQ_ILLEGAL_TRAP_EN: when defined, illegal/err_sticky are
// live; otherwise illegal opcodes retire as a one-cycle NOP and both error
// outputs are tied low.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned NUM_OPS = alu_seq_pkg::NUM_OPS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_op_sequencer_if.slave        op_if,
    output logic [NUM_OPS-1:0]       enable,
    output logic                     step,
    output logic [$clog2(WIDTH)-1:0] step_idx,
    output logic                     done,
    output logic                     busy,
    output logic                     illegal,
    output logic                     err_sticky,
    input  logic                     err_clr
);

    localparam int unsigned          IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(WIDTH - 1);

    seq_state_e         state_q, state_d;
    logic [NUM_OPS-1:0] onehot_q, onehot_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [NUM_OPS-1:0] dec_onehot;
    logic               dec_multi;
    logic               dec_legal;
    logic               accept;

    alu_op_decoder #(
        .OP_W (OP_W)
    ) u_dec (
        .opcode (op_if.opcode),
        .onehot (dec_onehot),
        .multi  (dec_multi),
        .legal  (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            onehot_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        step     = (state_q == ST_ITER);
        step_idx = idx_q;
        enable   = ((state_q == ST_SINGLE) || (state_q == ST_ITER)) ? onehot_q : '0;
        done     = (state_q == ST_SINGLE) || (state_q == ST_ILL) ||
                   ((state_q == ST_ITER) && (idx_q == LAST_IDX));

        // Ready in idle and in every retiring cycle so ops chain without a
        // bubble; held low while reset is asserted.
        op_if.op_ready = rst_n && ((state_q == ST_IDLE) || done);
        accept         = op_if.op_valid && op_if.op_ready;

        state_d  = state_q;
        onehot_d = onehot_q;
        idx_d    = idx_q;

        if (accept) begin
            onehot_d = dec_onehot;
            idx_d    = '0;
            if (!dec_legal) begin
                state_d = ST_ILL;
            end else if (dec_multi) begin
                state_d = ST_ITER;
            end else begin
                state_d = ST_SINGLE;
            end
        end else if (done) begin
            state_d  = ST_IDLE;
            onehot_d = '0;
            idx_d    = '0;
        end else if (state_q == ST_ITER) begin
            idx_d = idx_q + 1'b1;
        end
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic sticky_q;

    // Set on entry to ILL and again while in ILL, so a clear coinciding with
    // the illegal retirement cycle loses to the set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if ((accept && !dec_legal) || (state_q == ST_ILL)) begin
            sticky_q <= 1'b1;
        end else if (err_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign illegal    = (state_q == ST_ILL);
    assign err_sticky = sticky_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign illegal        = 1'b0;
    assign err_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer (WIDTH=4, OP_W=4). Each table row is
// one clock cycle: inputs held during the cycle, expected outputs observed
// during that same cycle. A few hand-written sequences follow for the
// iterative back-to-back and opcode-latching cases.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [11:0] enable;
    logic        step;
    logic [1:0]  step_idx;
    logic        done;
    logic        busy;
    logic        illegal;
    logic        err_sticky;
    logic        err_clr;

    int unsigned n_tests;
    int unsigned n_fail;

    alu_op_sequencer_if #(.OP_W(4)) op_if ();

    alu_op_sequencer #(
        .WIDTH   (4),
        .OP_W    (4),
        .NUM_OPS (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_if      (op_if.slave),
        .enable     (enable),
        .step       (step),
        .step_idx   (step_idx),
        .done       (done),
        .busy       (busy),
        .illegal    (illegal),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        v;
        logic [3:0]  op;
        logic        clr;
        logic        rdy;
        logic [11:0] en;
        logic        done;
        logic        step;
        logic [1:0]  idx;
        logic        busy;
        logic        ill;
        logic        sticky;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic r, input logic v, input logic [3:0] op, input logic clr,
        input logic rdy, input logic [11:0] en, input logic dn, input logic st,
        input logic [1:0] idx, input logic bz, input logic il, input logic sk);
        vec_t t;
        t.rst_n = r;   t.v = v;     t.op = op;    t.clr = clr;
        t.rdy = rdy;   t.en = en;   t.done = dn;  t.step = st;
        t.idx = idx;   t.busy = bz; t.ill = il;   t.sticky = sk;
        return t;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        err_clr = 1'b0;
        op_if.op_valid = 1'b0;
        op_if.opcode   = '0;

        //             rst v  op clr  rdy  en      dn st idx bz ill   sticky
        vq.push_back(mk(0, 0, 0,  0,  0, 12'h000, 0, 0, 0, 0, 0,    0));
        vq.push_back(mk(0, 1, 7,  0,  0, 12'h000, 0, 0, 0, 0, 0,    0));
        vq.push_back(mk(1, 1, 7,  0,  1, 12'h000, 0, 0, 0, 0, 0,    0));
        vq.push_back(mk(1, 0, 0,  0,  1, 12'h080, 1, 0, 0, 1, 0,    0));
        vq.push_back(mk(1, 0, 0,  0,  1, 12'h000, 0, 0, 0, 0, 0,    0));
        vq.push_back(mk(1, 1, 9,  0,  1, 12'h000, 0, 0, 0, 0, 0,    0));
        vq.push_back(mk(1, 0, 0,  0,  0, 12'h200, 0, 1, 0, 1, 0,    0));
        vq.push_back(mk(1, 1, 0,  0,  0, 12'h200, 0, 1, 1, 1, 0,    0));
        vq.push_back(mk(1, 1, 0,  0,  0, 12'h200, 0, 1, 2, 1, 0,    0));
        vq.push_back(mk(1, 1, 0,  0,  1, 12'h200, 1, 1, 3, 1, 0,    0));
        vq.push_back(mk(1, 1, 1,  0,  1, 12'h001, 1, 0, 0, 1, 0,    0));
        vq.push_back(mk(1, 1, 2,  0,  1, 12'h002, 1, 0, 0, 1, 0,    0));
        vq.push_back(mk(1, 0, 0,  0,  1, 12'h004, 1, 0, 0, 1, 0,    0));
        vq.push_back(mk(1, 1, 13, 0,  1, 12'h000, 0, 0, 0, 0, 0,    0));
        vq.push_back(mk(1, 0, 0,  0,  1, 12'h000, 1, 0, 0, 1, TRAP, TRAP));
        vq.push_back(mk(1, 0, 0,  0,  1, 12'h000, 0, 0, 0, 0, 0,    TRAP));
        vq.push_back(mk(1, 0, 0,  1,  1, 12'h000, 0, 0, 0, 0, 0,    TRAP));
        vq.push_back(mk(1, 0, 0,  0,  1, 12'h000, 0, 0, 0, 0, 0,    0));
        vq.push_back(mk(1, 1, 15, 0,  1, 12'h000, 0, 0, 0, 0, 0,    0));
        vq.push_back(mk(1, 0, 0,  1,  1, 12'h000, 1, 0, 0, 1, TRAP, TRAP));
        vq.push_back(mk(1, 0, 0,  0,  1, 12'h000, 0, 0, 0, 0, 0,    TRAP));
        vq.push_back(mk(1, 0, 0,  1,  1, 12'h000, 0, 0, 0, 0, 0,    TRAP));
        vq.push_back(mk(1, 1, 10, 0,  1, 12'h000, 0, 0, 0, 0, 0,    0));
        vq.push_back(mk(1, 0, 0,  0,  0, 12'h400, 0, 1, 0, 1, 0,    0));
        vq.push_back(mk(1, 0, 0,  0,  0, 12'h400, 0, 1, 1, 1, 0,    0));
        vq.push_back(mk(0, 0, 0,  0,  0, 12'h400, 0, 1, 2, 1, 0,    0));
        vq.push_back(mk(1, 0, 0,  0,  1, 12'h000, 0, 0, 0, 0, 0,    0));
        vq.push_back(mk(1, 1, 11, 0,  1, 12'h000, 0, 0, 0, 0, 0,    0));
        vq.push_back(mk(1, 0, 0,  0,  1, 12'h800, 1, 0, 0, 1, 0,    0));

        tick();
        for (int i = 0; i < vq.size(); i++) begin
            rst_n          = vq[i].rst_n;
            op_if.op_valid = vq[i].v;
            op_if.opcode   = vq[i].op;
            err_clr        = vq[i].clr;
            #1;
            chk("op_ready",   i, 32'(op_if.op_ready), 32'(vq[i].rdy));
            chk("enable",     i, 32'(enable),         32'(vq[i].en));
            chk("done",       i, 32'(done),           32'(vq[i].done));
            chk("step",       i, 32'(step),           32'(vq[i].step));
            chk("step_idx",   i, 32'(step_idx),       32'(vq[i].idx));
            chk("busy",       i, 32'(busy),           32'(vq[i].busy));
            chk("illegal",    i, 32'(illegal),        32'(vq[i].ill));
            chk("err_sticky", i, 32'(err_sticky),     32'(vq[i].sticky));
            tick();
        end

        // MULT with the opcode input changed after accept, then DIV chained
        // on the last MULT iteration with no idle bubble.
        err_clr        = 1'b0;
        op_if.op_valid = 1'b1;
        op_if.opcode   = 4'd9;
        #1;
        chk("seq_mult_ready", 100, 32'(op_if.op_ready), 32'd1);
        tick();
        op_if.op_valid = 1'b0;
        op_if.opcode   = 4'd3;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                op_if.op_valid = 1'b1;
                op_if.opcode   = 4'd10;
            end
            #1;
            chk("seq_mult_en",    100 + c, 32'(enable),         32'h200);
            chk("seq_mult_idx",   100 + c, 32'(step_idx),       32'(c));
            chk("seq_mult_done",  100 + c, 32'(done),           32'(c == 3));
            chk("seq_mult_ready", 100 + c, 32'(op_if.op_ready), 32'(c == 3));
            tick();
        end
        op_if.op_valid = 1'b0;
        op_if.opcode   = 4'd0;
        #1;
        chk("seq_div_en",   110, 32'(enable),   32'h400);
        chk("seq_div_idx",  110, 32'(step_idx), 32'd0);
        chk("seq_div_step", 110, 32'(step),     32'd1);

        // Bounded wait for DIV completion: three more cycles after idx 0.
        cnt = 0;
        while (!done && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("seq_div_done_seen",  111, 32'(done),     32'd1);
        chk("seq_div_done_delay", 111, 32'(cnt),      32'd3);
        chk("seq_div_done_idx",   111, 32'(step_idx), 32'd3);
        tick();
        chk("seq_idle_busy",  112, 32'(busy),   32'd0);
        chk("seq_idle_en",    112, 32'(enable), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
